record_framer: RTL
==================

RECORD_FRAMER -- requirements
Module: record_framer

Interface
REQ-001 The module SHALL have parameter SOF, default 8'h7E, meaning the start-of-frame byte.
REQ-002 The module SHALL have parameter ESC, default 8'h7D, meaning the escape byte.
REQ-003 The module SHALL have parameter ESC_XOR, default 8'h20, meaning the mask XORed into an escaped byte.
REQ-004 The module SHALL have port clock  input  1  single system clock; all logic is on its rising edge.
REQ-005 The module SHALL have port reset  input  1  asynchronous, active-low reset.
REQ-006 The module SHALL have port read_empty  input  1  ring buffer holds no record.
REQ-007 The module SHALL have port read_data  input  48  record {addr[47:16], data[15:8], flags[7:0]}, valid the cycle after a read_clock_enable pulse.
REQ-008 The module SHALL have port read_clock_enable  output  1  one-cycle pop strobe to the ring buffer.
REQ-009 The module SHALL have port uart_ready  input  1  FTDI transmitter can accept a byte.
REQ-010 The module SHALL have port uart_data  output  8  byte to transmit.
REQ-011 The module SHALL have port uart_clock_enable  output  1  one-cycle byte strobe; uart_data is valid in the same cycle.
REQ-012 The module SHALL have port busy  output  1  high whenever the state is not IDLE.

Function
REQ-013 Each record SHALL go out as one frame: SOF, then payload bytes read_data[47:40] down to [7:0] (6 bytes, MSB first), then CHK, where CHK is the XOR of the 6 unescaped payload bytes.
REQ-014 Any payload or CHK byte equal to SOF or ESC SHALL be sent as ESC followed by (byte XOR ESC_XOR); SOF itself SHALL never be escaped.
REQ-015 The state machine SHALL have the states IDLE, POP, LATCH, SEND_SOF, SEND_BYTE, SEND_ESC2 and SEND_CHK.
REQ-016 In IDLE with read_empty=0, the module SHALL assert read_clock_enable for exactly one cycle and enter POP.
REQ-017 POP SHALL wait one cycle; in LATCH the module SHALL register read_data into a 48-bit shift register, clear the byte index (0..5) and the checksum accumulator, and enter SEND_SOF.
REQ-018 A byte strobe SHALL be issued only when uart_ready=1 and no strobe was issued in the previous cycle, so at least one idle cycle separates any two strobes.
REQ-019 In SEND_BYTE, a strobe SHALL emit the current byte, or ESC if escaping applies; the checksum SHALL update with the unescaped byte at that strobe.
REQ-020 After an ESC strobe, the state SHALL go to SEND_ESC2, which emits the escaped byte and then returns to SEND_BYTE with the index advanced, or goes to SEND_CHK after index 5.
REQ-021 SEND_CHK SHALL emit CHK, via SEND_ESC2 if CHK needs escaping, and then return to IDLE.
REQ-022 Minimum frame length SHALL be 8 bytes and maximum 15 bytes.
REQ-023 read_clock_enable SHALL never be asserted while read_empty=1 or outside IDLE, so at most one record is in flight.
REQ-024 If read_empty rises during a frame, the frame SHALL still complete; the next pop SHALL wait in IDLE.
REQ-025 If uart_ready is low for any number of cycles, the state, uart_data and the shift register SHALL hold; no byte is lost or duplicated.
REQ-026 From IDLE with data pending and a ready UART, the first strobe (SOF) SHALL come exactly 3 cycles after the pop strobe.

Reset
REQ-027 While reset=0, the module SHALL force state=IDLE, read_clock_enable=0, uart_clock_enable=0, uart_data=8'h00, busy=0, and clear the shift register, index and checksum.
REQ-028 If reset is asserted mid-frame, the module SHALL abandon the partial frame with no further strobes; the host resynchronises on the next SOF, and the popped record is lost.
REQ-029 On reset release, the first pop SHALL occur no earlier than the first rising clock edge after deassertion.

Structure
REQ-030 A shared package SHALL hold the state enum, the default SOF, ESC and ESC_XOR constants, and the record field offsets (ADDR_MSB=47, DATA_MSB=15, FLAGS_MSB=7), for reuse by the host-side model and the bench.
REQ-031 The design SHALL be a single module; the escape decision (byte==SOF || byte==ESC) SHALL be a combinational function in the package, not a sub-module.

Verification
REQ-032 With record 48'h0000_0080_3402 and uart_ready=1 constant, the bench SHALL see bytes 7E 00 00 00 80 34 02 B6 with strobes 2 cycles apart.
REQ-033 With record 48'h7E7D_0000_0000, the bench SHALL see bytes 7E 7D 5E 7D 5D 00 00 00 00 03.
REQ-034 With a record whose CHK equals 7E (e.g. 48'h0000_0000_007E), the bench SHALL see the payload 00 00 00 00 00 7D 5E followed by CHK sent as 7D 5E.
REQ-035 With 3 records queued, uart_ready toggling randomly and the ring buffer modelled with a one-cycle read latency, the bench SHALL see exactly 3 pops and 3 intact frames, and no pop while read_empty=1.
REQ-036 With reset asserted after the 3rd byte of a frame, outputs SHALL be 0 immediately; after release with one record queued, the next byte SHALL be a fresh SOF.
REQ-037 With uart_ready held low for 100 cycles mid-frame, the bench SHALL see no strobe, uart_data stable, and the frame resuming with the correct next byte.

Source files
------------

// File: rtl/record_framer_pkg.sv
// rtl/record_framer_pkg.sv - shared types and constants for the record framer
// Holds the framer state enum, the default framing bytes, the record field
// offsets and the escape decision. Shared by the RTL, the host-side model and
// the bench.
package record_framer_pkg;

  typedef enum logic [2:0] {
    IDLE,
    POP,
    LATCH,
    SEND_SOF,
    SEND_BYTE,
    SEND_ESC2,
    SEND_CHK
  } state_t;

  localparam logic [7:0] SOF_DEFAULT     = 8'h7E;
  localparam logic [7:0] ESC_DEFAULT     = 8'h7D;
  localparam logic [7:0] ESC_XOR_DEFAULT = 8'h20;

  // Record layout: {addr[47:16], data[15:8], flags[7:0]}
  localparam int ADDR_MSB  = 47;
  localparam int DATA_MSB  = 15;
  localparam int FLAGS_MSB = 7;
  localparam int REC_W     = 48;

  // A byte that collides with either framing byte must be escaped.
  function automatic logic needs_escape(input logic [7:0] b,
                                        input logic [7:0] sof,
                                        input logic [7:0] esc);
    return (b == sof) || (b == esc);
  endfunction

endpackage

// File: rtl/record_framer.sv
// rtl/record_framer.sv - pops 48-bit records and sends them as escaped UART frames
// Frame: SOF, 6 payload bytes MSB first, CHK (XOR of unescaped payload).
// Ports:
//   clock             system clock, rising edge
//   reset             asynchronous active-low reset
//   read_empty        ring buffer has no record
//   read_data         record, valid the cycle after read_clock_enable
//   read_clock_enable one-cycle pop strobe
//   uart_ready        transmitter can accept a byte
//   uart_data         byte to transmit, valid with uart_clock_enable
//   uart_clock_enable one-cycle byte strobe
//   busy              state is not IDLE
module record_framer
  import record_framer_pkg::*;
#(
  parameter logic [7:0] SOF     = SOF_DEFAULT,
  parameter logic [7:0] ESC     = ESC_DEFAULT,
  parameter logic [7:0] ESC_XOR = ESC_XOR_DEFAULT
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             read_empty,
  input  logic [REC_W-1:0] read_data,
  output logic             read_clock_enable,
  input  logic             uart_ready,
  output logic [7:0]       uart_data,
  output logic             uart_clock_enable,
  output logic             busy
);

  state_t           state_q, state_d;
  logic [REC_W-1:0] shift_q, shift_d;
  logic [2:0]       index_q, index_d;
  logic [7:0]       chk_q, chk_d;
  logic             from_chk_q, from_chk_d;   // SEND_ESC2 is finishing the CHK byte
  logic             rce_q, rce_d;
  logic             uce_q, uce_d;
  logic [7:0]       data_q, data_d;

  logic             can_send;
  logic [7:0]       cur_byte;

  // A strobe is never issued in two consecutive cycles.
  assign can_send = uart_ready && !uce_q;
  assign cur_byte = shift_q[ADDR_MSB -: 8];

  always_comb begin
    state_d    = state_q;
    shift_d    = shift_q;
    index_d    = index_q;
    chk_d      = chk_q;
    from_chk_d = from_chk_q;
    rce_d      = 1'b0;
    uce_d      = 1'b0;
    data_d     = data_q;

    case (state_q)
      IDLE: begin
        if (!read_empty) begin
          rce_d   = 1'b1;
          state_d = POP;
        end
      end
      POP: begin
        state_d = LATCH;
      end
      LATCH: begin
        shift_d    = read_data;
        index_d    = 3'd0;
        chk_d      = 8'h00;
        from_chk_d = 1'b0;
        state_d    = SEND_SOF;
      end
      SEND_SOF: begin
        if (can_send) begin
          uce_d   = 1'b1;
          data_d  = SOF;
          state_d = SEND_BYTE;
        end
      end
      SEND_BYTE: begin
        if (can_send) begin
          uce_d = 1'b1;
          chk_d = chk_q ^ cur_byte;
          if (needs_escape(cur_byte, SOF, ESC)) begin
            // Shift register keeps the byte; SEND_ESC2 emits it masked.
            data_d  = ESC;
            state_d = SEND_ESC2;
          end else begin
            data_d  = cur_byte;
            shift_d = {shift_q[REC_W-9:0], 8'h00};
            index_d = index_q + 3'd1;
            state_d = (index_q == 3'd5) ? SEND_CHK : SEND_BYTE;
          end
        end
      end
      SEND_ESC2: begin
        if (can_send) begin
          uce_d = 1'b1;
          if (from_chk_q) begin
            data_d  = chk_q ^ ESC_XOR;
            state_d = IDLE;
          end else begin
            data_d  = cur_byte ^ ESC_XOR;
            shift_d = {shift_q[REC_W-9:0], 8'h00};
            index_d = index_q + 3'd1;
            state_d = (index_q == 3'd5) ? SEND_CHK : SEND_BYTE;
          end
        end
      end
      SEND_CHK: begin
        if (can_send) begin
          uce_d = 1'b1;
          if (needs_escape(chk_q, SOF, ESC)) begin
            data_d     = ESC;
            from_chk_d = 1'b1;
            state_d    = SEND_ESC2;
          end else begin
            data_d  = chk_q;
            state_d = IDLE;
          end
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q    <= IDLE;
      shift_q    <= '0;
      index_q    <= 3'd0;
      chk_q      <= 8'h00;
      from_chk_q <= 1'b0;
      rce_q      <= 1'b0;
      uce_q      <= 1'b0;
      data_q     <= 8'h00;
    end else begin
      state_q    <= state_d;
      shift_q    <= shift_d;
      index_q    <= index_d;
      chk_q      <= chk_d;
      from_chk_q <= from_chk_d;
      rce_q      <= rce_d;
      uce_q      <= uce_d;
      data_q     <= data_d;
    end
  end

  assign read_clock_enable = rce_q;
  assign uart_clock_enable = uce_q;
  assign uart_data         = data_q;
  assign busy              = (state_q != IDLE);

endmodule
